// File: rtl/entry_sequencer.sv
// Credential entry front end: gathers 8 five-bit symbols, requests a check,
// tracks the verdict with a timeout and enforces a lockout after repeated failures.
module entry_sequencer #(
  parameter int MAX_FAIL       = 3,
  parameter int VERIFY_TIMEOUT = 16,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sym_in,
  input  logic        sym_valid,
  input  logic        sym_del,
  input  logic        sym_clear,
  input  logic        clear_ack,
  input  logic        lock_in,
  output logic [19:0] user_name,
  output logic [19:0] password,
  output logic [3:0]  input_count,
  output logic        check_req,
  output logic        lockout,
  output logic [3:0]  fail_count
);

  localparam int TMAX = (VERIFY_TIMEOUT > LOCKOUT_CYCLES) ? VERIFY_TIMEOUT : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    CHECK    = 2'd1,
    LOCKOUT  = 2'd2,
    UNLOCKED = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [39:0]     buf_r, buf_s, edit_buf_s;
  logic [3:0]      count_r, count_s, edit_count_s;
  logic            check_req_r, check_req_s;
  logic            lockout_r, lockout_s;
  logic [3:0]      fail_r, fail_s, fail_inc_s;
  logic [TW-1:0]   timer_r, timer_s;

  // Buffer after applying this cycle's edit (clear > delete > append); slot k at [5k+4:5k].
  always_comb begin
    edit_buf_s   = buf_r;
    edit_count_s = count_r;
    if (sym_clear) begin
      edit_buf_s   = 40'd0;
      edit_count_s = 4'd0;
    end else if (sym_del) begin
      if (count_r != 4'd0) begin
        for (int k = 0; k < 8; k++) begin
          if (4'(k) == (count_r - 4'd1)) begin
            edit_buf_s[5*k +: 5] = 5'd0;
          end else begin
            edit_buf_s[5*k +: 5] = buf_r[5*k +: 5];
          end
        end
        edit_count_s = count_r - 4'd1;
      end else begin
        edit_count_s = count_r;
      end
    end else if (sym_valid) begin
      if (count_r < 4'd8) begin
        for (int k = 0; k < 8; k++) begin
          if (4'(k) == count_r) begin
            edit_buf_s[5*k +: 5] = sym_in;
          end else begin
            edit_buf_s[5*k +: 5] = buf_r[5*k +: 5];
          end
        end
        edit_count_s = count_r + 4'd1;
      end else begin
        edit_count_s = count_r;
      end
    end else begin
      edit_buf_s   = buf_r;
      edit_count_s = count_r;
    end
  end

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_s     = state_r;
    buf_s       = buf_r;
    count_s     = count_r;
    check_req_s = check_req_r;
    lockout_s   = lockout_r;
    fail_s      = fail_r;
    timer_s     = timer_r;
    fail_inc_s  = fail_r + 4'd1;
    case (state_r)
      ENTRY: begin
        // A full buffer launches a check unless the user is editing it this cycle.
        if ((count_r == 4'd8) && !sym_clear && !sym_del) begin
          state_s     = CHECK;
          check_req_s = 1'b1;
          timer_s     = '0;
        end else begin
          buf_s   = edit_buf_s;
          count_s = edit_count_s;
        end
      end
      CHECK: begin
        if (clear_ack && !lock_in) begin
          state_s     = UNLOCKED;
          buf_s       = 40'd0;
          count_s     = 4'd0;
          check_req_s = 1'b0;
          fail_s      = 4'd0;
          timer_s     = '0;
        end else if (timer_r == TW'(VERIFY_TIMEOUT - 1)) begin
          buf_s       = 40'd0;
          count_s     = 4'd0;
          check_req_s = 1'b0;
          fail_s      = fail_inc_s;
          timer_s     = '0;
          if (fail_inc_s == 4'(MAX_FAIL)) begin
            state_s   = LOCKOUT;
            lockout_s = 1'b1;
          end else begin
            state_s   = ENTRY;
          end
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      LOCKOUT: begin
        buf_s   = 40'd0;
        count_s = 4'd0;
        if (timer_r == TW'(LOCKOUT_CYCLES - 1)) begin
          state_s   = ENTRY;
          lockout_s = 1'b0;
          fail_s    = 4'd0;
          timer_s   = '0;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      UNLOCKED: begin
        if (lock_in) begin
          state_s = ENTRY;
          buf_s   = 40'd0;
          count_s = 4'd0;
          timer_s = '0;
        end else if (clear_ack) begin
          buf_s   = 40'd0;
          count_s = 4'd0;
        end else begin
          buf_s   = edit_buf_s;
          count_s = edit_count_s;
        end
      end
      default: begin
        state_s     = ENTRY;
        buf_s       = 40'd0;
        count_s     = 4'd0;
        check_req_s = 1'b0;
        lockout_s   = 1'b0;
        fail_s      = 4'd0;
        timer_s     = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ENTRY;
      buf_r       <= 40'd0;
      count_r     <= 4'd0;
      check_req_r <= 1'b0;
      lockout_r   <= 1'b0;
      fail_r      <= 4'd0;
      timer_r     <= '0;
    end else begin
      state_r     <= state_s;
      buf_r       <= buf_s;
      count_r     <= count_s;
      check_req_r <= check_req_s;
      lockout_r   <= lockout_s;
      fail_r      <= fail_s;
      timer_r     <= timer_s;
    end
  end

  assign user_name   = buf_r[19:0];
  assign password    = buf_r[39:20];
  assign input_count = count_r;
  assign check_req   = check_req_r;
  assign lockout     = lockout_r;
  assign fail_count  = fail_r;

endmodule

// File: tb/tb_entry_sequencer.sv
// Directed self-checking bench for entry_sequencer with
// VERIFY_TIMEOUT=16, LOCKOUT_CYCLES=20, MAX_FAIL=3.
module tb_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  sym_in;
  logic        sym_valid, sym_del, sym_clear, clear_ack, lock_in;
  logic [19:0] user_name, password;
  logic [3:0]  input_count, fail_count;
  logic        check_req, lockout;

  int n_cmp = 0;
  int n_err = 0;

  entry_sequencer #(.MAX_FAIL(3), .VERIFY_TIMEOUT(16), .LOCKOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_del(sym_del),
    .sym_clear(sym_clear), .clear_ack(clear_ack), .lock_in(lock_in),
    .user_name(user_name), .password(password), .input_count(input_count),
    .check_req(check_req), .lockout(lockout), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sym(input logic [4:0] v);
    sym_in = v; sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic fill(input logic [4:0] base);
    for (int i = 0; i < 8; i++) pulse_sym(base + 5'(i));
  endtask

  // One failed attempt: fill, enter CHECK, wait (bounded) for the verdict.
  task automatic run_fail_attempt(output int n);
    fill(5'd1);
    tick();
    n = 0;
    while (check_req === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({user_name, password} !== 40'd0) begin n_err++; $display("FAIL reset_buf got %h want 0", {user_name, password}); end
    n_cmp++; if ({input_count, check_req, lockout, fail_count} !== 10'd0) begin n_err++; $display("FAIL reset_ctl got %h want 0", {input_count, check_req, lockout, fail_count}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_unlock();
    fill(5'd1);
    n_cmp++; if (input_count !== 4'd8) begin n_err++; $display("FAIL fill_count got %0d want 8", input_count); end
    n_cmp++; if (user_name !== 20'h20C41) begin n_err++; $display("FAIL fill_user got %h want 20c41", user_name); end
    n_cmp++; if (password !== 20'h41CC5) begin n_err++; $display("FAIL fill_pass got %h want 41cc5", password); end
    n_cmp++; if (check_req !== 1'b0) begin n_err++; $display("FAIL fill_req_early got %b want 0", check_req); end
    tick();
    n_cmp++; if (check_req !== 1'b1) begin n_err++; $display("FAIL check_req got %b want 1", check_req); end
    tick(); tick();
    clear_ack = 1'b1;
    tick();
    clear_ack = 1'b0;
    n_cmp++; if ({check_req, input_count, fail_count} !== 9'd0) begin n_err++; $display("FAIL unlock got %h want 0", {check_req, input_count, fail_count}); end
    n_cmp++; if ({user_name, password} !== 40'd0) begin n_err++; $display("FAIL unlock_buf got %h want 0", {user_name, password}); end
    pulse_sym(5'd9);
    n_cmp++; if (user_name !== 20'd9 || input_count !== 4'd1) begin n_err++; $display("FAIL unlocked_edit got %h/%0d want 9/1", user_name, input_count); end
    lock_in = 1'b1;
    tick();
    lock_in = 1'b0;
    n_cmp++; if (input_count !== 4'd0 || user_name !== 20'd0) begin n_err++; $display("FAIL relock got %h/%0d want 0/0", user_name, input_count); end
    // In ENTRY lock_in is ignored, so the append must land.
    lock_in = 1'b1;
    pulse_sym(5'd6);
    lock_in = 1'b0;
    n_cmp++; if (input_count !== 4'd1 || user_name !== 20'd6) begin n_err++; $display("FAIL entry_lock_ignored got %h/%0d want 6/1", user_name, input_count); end
    sym_clear = 1'b1; tick(); sym_clear = 1'b0;
  endtask

  task automatic test_edits();
    pulse_sym(5'd3);
    pulse_sym(5'd9);
    n_cmp++; if (user_name !== 20'h00123) begin n_err++; $display("FAIL edit_two got %h want 00123", user_name); end
    sym_del = 1'b1; tick(); sym_del = 1'b0;
    n_cmp++; if (input_count !== 4'd1 || user_name !== 20'd3) begin n_err++; $display("FAIL edit_del got %h/%0d want 3/1", user_name, input_count); end
    sym_del = 1'b1; sym_valid = 1'b1; sym_in = 5'd7; tick(); sym_del = 1'b0; sym_valid = 1'b0;
    n_cmp++; if (input_count !== 4'd0 || user_name !== 20'd0) begin n_err++; $display("FAIL edit_del_prio got %h/%0d want 0/0", user_name, input_count); end
    sym_del = 1'b1; tick(); sym_del = 1'b0;
    n_cmp++; if (input_count !== 4'd0) begin n_err++; $display("FAIL edit_del_empty got %0d want 0", input_count); end
    for (int i = 1; i <= 5; i++) pulse_sym(5'(i));
    n_cmp++; if (input_count !== 4'd5 || password !== 20'd5) begin n_err++; $display("FAIL edit_five got %h/%0d want 5/5", password, input_count); end
    sym_clear = 1'b1; sym_valid = 1'b1; sym_in = 5'd2; tick(); sym_clear = 1'b0; sym_valid = 1'b0;
    n_cmp++; if (input_count !== 4'd0 || {user_name, password} !== 40'd0) begin n_err++; $display("FAIL edit_clear got %0d want 0", input_count); end
  endtask

  task automatic test_lockout();
    int n;
    fill(5'd1);
    tick();
    sym_del = 1'b1; tick(); sym_del = 1'b0;
    n_cmp++; if (input_count !== 4'd8 || check_req !== 1'b1) begin n_err++; $display("FAIL check_frozen got %0d/%b want 8/1", input_count, check_req); end
    n = 1;
    while (check_req === 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++; if (n !== 16) begin n_err++; $display("FAIL check_len1 got %0d want 16", n); end
    n_cmp++; if (fail_count !== 4'd1 || input_count !== 4'd0) begin n_err++; $display("FAIL fail1 got %0d/%0d want 1/0", fail_count, input_count); end
    run_fail_attempt(n);
    n_cmp++; if (n !== 16 || fail_count !== 4'd2 || lockout !== 1'b0) begin n_err++; $display("FAIL fail2 got %0d/%0d/%b want 16/2/0", n, fail_count, lockout); end
    run_fail_attempt(n);
    n_cmp++; if (n !== 16 || fail_count !== 4'd3 || lockout !== 1'b1) begin n_err++; $display("FAIL fail3 got %0d/%0d/%b want 16/3/1", n, fail_count, lockout); end
    pulse_sym(5'd7);
    n_cmp++; if (input_count !== 4'd0) begin n_err++; $display("FAIL lock_ignore got %0d want 0", input_count); end
    n = 1;
    while (lockout === 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++; if (n !== 20 || fail_count !== 4'd0) begin n_err++; $display("FAIL lock_len got %0d/%0d want 20/0", n, fail_count); end
    pulse_sym(5'd6);
    n_cmp++; if (input_count !== 4'd1) begin n_err++; $display("FAIL post_lock_entry got %0d want 1", input_count); end
    sym_clear = 1'b1; tick(); sym_clear = 1'b0;
  endtask

  task automatic test_timeout_edge();
    int n;
    run_fail_attempt(n);
    n_cmp++; if (fail_count !== 4'd1) begin n_err++; $display("FAIL edge_pre got %0d want 1", fail_count); end
    fill(5'd1);
    tick();
    repeat (15) tick();
    clear_ack = 1'b1; tick(); clear_ack = 1'b0;
    n_cmp++; if ({check_req, lockout, fail_count, input_count} !== 10'd0) begin n_err++; $display("FAIL edge_success got %h want 0", {check_req, lockout, fail_count, input_count}); end
  endtask

  task automatic test_unlocked();
    fill(5'd10);
    repeat (3) tick();
    n_cmp++; if (check_req !== 1'b0 || input_count !== 4'd8) begin n_err++; $display("FAIL unl_no_check got %b/%0d want 0/8", check_req, input_count); end
    pulse_sym(5'd31);
    n_cmp++; if (input_count !== 4'd8 || password !== 20'h8C1EE) begin n_err++; $display("FAIL unl_full got %h/%0d want 8c1ee/8", password, input_count); end
    clear_ack = 1'b1; sym_valid = 1'b1; sym_in = 5'd4; tick(); clear_ack = 1'b0; sym_valid = 1'b0;
    n_cmp++; if (input_count !== 4'd0 || user_name !== 20'd0) begin n_err++; $display("FAIL unl_ack got %h/%0d want 0/0", user_name, input_count); end
    pulse_sym(5'd2);
    lock_in = 1'b1; clear_ack = 1'b1; sym_valid = 1'b1; sym_in = 5'd3; tick();
    lock_in = 1'b0; clear_ack = 1'b0; sym_valid = 1'b0;
    n_cmp++; if (input_count !== 4'd0 || user_name !== 20'd0) begin n_err++; $display("FAIL unl_lock got %h/%0d want 0/0", user_name, input_count); end
  endtask

  task automatic test_reset_lockout();
    int n;
    for (int a = 0; a < 3; a++) run_fail_attempt(n);
    n_cmp++; if (lockout !== 1'b1) begin n_err++; $display("FAIL rl_enter got %b want 1", lockout); end
    repeat (7) tick();
    #3 rst = 1'b1;
    #1;
    n_cmp++; if ({lockout, check_req, fail_count, input_count} !== 10'd0) begin n_err++; $display("FAIL rl_async got %h want 0", {lockout, check_req, fail_count, input_count}); end
    rst = 1'b0;
    tick();
    pulse_sym(5'd5);
    n_cmp++; if (input_count !== 4'd1 || user_name !== 20'd5 || lockout !== 1'b0) begin n_err++; $display("FAIL rl_entry got %h/%0d want 5/1", user_name, input_count); end
  endtask

  initial begin
    rst = 1'b1; sym_in = 5'd0; sym_valid = 1'b0; sym_del = 1'b0; sym_clear = 1'b0;
    clear_ack = 1'b0; lock_in = 1'b0;
    test_reset();
    test_fill_unlock();
    test_edits();
    test_lockout();
    test_timeout_edge();
    test_unlocked();
    test_reset_lockout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
